// File: rtl/agc_pkg.sv
// Shared types and helpers for the AGC controller: FSM encoding, VGA adjust
// directions and counter-width sizing.
package agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } agc_state_t;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'd0,
    ADJ_UP   = 2'd1,
    ADJ_DN   = 2'd2
  } adj_dir_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/agc_step_sat.sv
// Saturating VGA code step: adds or subtracts VGA_STEP, clamping at the code
// range limits instead of wrapping.
module agc_step_sat
  import agc_pkg::*;
#(
  parameter int unsigned VGA_W    = 5,
  parameter int unsigned VGA_STEP = 1
) (
  input  logic [VGA_W-1:0] vga,
  input  adj_dir_t         dir,
  output logic [VGA_W-1:0] vga_next_c
);

  localparam int unsigned VMAX = (1 << VGA_W) - 1;

  logic [31:0] up_sum;

  always_comb begin
    up_sum     = 32'(vga) + VGA_STEP;
    vga_next_c = vga;
    case (dir)
      ADJ_UP:  vga_next_c = (up_sum > VMAX) ? VGA_W'(VMAX) : VGA_W'(up_sum);
      ADJ_DN:  vga_next_c = (32'(vga) < VGA_STEP) ? '0 : VGA_W'(32'(vga) - VGA_STEP);
      default: vga_next_c = vga;
    endcase
  end

endmodule

// File: rtl/agc_ctrl_param.sv
// AGC controller: steps LNA/VGA gain codes from RSSI/power measurements with
// settle timing, hysteretic lock detection and a manual override.
module agc_ctrl_param
  import agc_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LNA_W        = 2,
  parameter int unsigned VGA_W        = 5,
  parameter int unsigned LNA_MAX      = 3,
  parameter int unsigned LNA_MIN      = 1,
  parameter int unsigned RSSI_HI      = 140,
  parameter int unsigned RSSI_LO      = 80,
  parameter int unsigned PWR_LO       = 90,
  parameter int unsigned PWR_HI       = 150,
  parameter int unsigned HYST         = 10,
  parameter int unsigned VGA_STEP     = 1,
  parameter int unsigned VGA_AFTER_DN = 13,
  parameter int unsigned VGA_AFTER_UP = 8,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned LOCK_CNT     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   manual,
  input  logic [LNA_W+VGA_W-1:0] man_gain_in,
  input  logic                   meas_valid,
  input  logic [DATA_W-1:0]      rssi_in,
  input  logic [DATA_W-1:0]      pwr_in,
  output logic [LNA_W+VGA_W-1:0] gain_out,
  output logic                   gain_upd,
  output logic                   settling,
  output logic                   locked
);

  localparam int unsigned SET_W = cnt_w(SETTLE_CYC);
  localparam int unsigned WIN_W = cnt_w(LOCK_CNT);

  localparam logic [DATA_W-1:0] TH_RSSI_HI = DATA_W'(RSSI_HI);
  localparam logic [DATA_W-1:0] TH_RSSI_LO = DATA_W'(RSSI_LO);
  localparam logic [DATA_W-1:0] TH_PWR_LO  = DATA_W'(PWR_LO);
  localparam logic [DATA_W-1:0] TH_PWR_HI  = DATA_W'(PWR_HI);
  localparam logic [DATA_W-1:0] TH_EXIT_LO = DATA_W'(PWR_LO - HYST);
  localparam logic [DATA_W-1:0] TH_EXIT_HI = DATA_W'(PWR_HI + HYST);
  localparam logic [LNA_W-1:0]  LNA_MAX_V  = LNA_W'(LNA_MAX);
  localparam logic [LNA_W-1:0]  LNA_MIN_V  = LNA_W'(LNA_MIN);
  localparam logic [VGA_W-1:0]  VGA_DN_V   = VGA_W'(VGA_AFTER_DN);
  localparam logic [VGA_W-1:0]  VGA_UP_V   = VGA_W'(VGA_AFTER_UP);
  localparam logic [SET_W-1:0]  SET_LOAD   = SET_W'(SETTLE_CYC);
  localparam logic [WIN_W-1:0]  WIN_LOCK   = WIN_W'(LOCK_CNT);

  agc_state_t       state_q, state_n;
  logic [LNA_W-1:0] lna_q, lna_n;
  logic [VGA_W-1:0] vga_q, vga_n;
  logic [SET_W-1:0] set_cnt_q, set_cnt_n;
  logic [WIN_W-1:0] win_q, win_n, win_inc_c;
  logic             upd_n;

  adj_dir_t         vga_dir_c;
  logic [VGA_W-1:0] vga_step_c;
  logic [LNA_W-1:0] adj_lna_c;
  logic [VGA_W-1:0] adj_vga_c;
  logic             lna_dn_c, lna_up_c, changed_c, in_win_c, exit_c;

  assign gain_out = {lna_q, vga_q};

  agc_step_sat #(
    .VGA_W    (VGA_W),
    .VGA_STEP (VGA_STEP)
  ) u_step (
    .vga        (vga_q),
    .dir        (vga_dir_c),
    .vga_next_c (vga_step_c)
  );

  // Candidate gain from the adjust rule; LNA down wins over LNA up over VGA.
  always_comb begin
    lna_dn_c  = (rssi_in > TH_RSSI_HI) && (lna_q > LNA_MIN_V);
    lna_up_c  = (rssi_in < TH_RSSI_LO) && (lna_q < LNA_MAX_V);
    vga_dir_c = ADJ_NONE;
    if (pwr_in < TH_PWR_LO)      vga_dir_c = ADJ_UP;
    else if (pwr_in > TH_PWR_HI) vga_dir_c = ADJ_DN;
    adj_lna_c = lna_q;
    adj_vga_c = vga_step_c;
    if (lna_dn_c) begin
      adj_lna_c = lna_q - LNA_W'(1);
      adj_vga_c = VGA_DN_V;
    end else if (lna_up_c) begin
      adj_lna_c = lna_q + LNA_W'(1);
      adj_vga_c = VGA_UP_V;
    end
    changed_c = ({adj_lna_c, adj_vga_c} != {lna_q, vga_q});
    in_win_c  = (pwr_in >= TH_PWR_LO) && (pwr_in <= TH_PWR_HI);
    exit_c    = (pwr_in < TH_EXIT_LO) || (pwr_in > TH_EXIT_HI) || lna_dn_c || lna_up_c;
    win_inc_c = win_q + WIN_W'(1);
  end

  // Next-state and register-input decode.
  always_comb begin
    state_n   = state_q;
    lna_n     = lna_q;
    vga_n     = vga_q;
    set_cnt_n = set_cnt_q;
    win_n     = win_q;
    upd_n     = 1'b0;
    if (manual) begin
      {lna_n, vga_n} = man_gain_in;
      upd_n          = (man_gain_in != {lna_q, vga_q});
      state_n        = ST_IDLE;
      win_n          = '0;
    end else if (!en) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_n = ST_TRACK;
        ST_TRACK: begin
          if (meas_valid) begin
            if (changed_c) begin
              lna_n     = adj_lna_c;
              vga_n     = adj_vga_c;
              upd_n     = 1'b1;
              state_n   = ST_SETTLE;
              set_cnt_n = SET_LOAD;
              win_n     = '0;
            end else if (in_win_c) begin
              win_n = win_inc_c;
              if (win_inc_c == WIN_LOCK) state_n = ST_LOCKED;
            end else begin
              win_n = '0;
            end
          end
        end
        ST_SETTLE: begin
          // Leave on the cycle the counter would reach zero.
          if (set_cnt_q <= SET_W'(1)) begin
            state_n   = ST_TRACK;
            set_cnt_n = '0;
          end else begin
            set_cnt_n = set_cnt_q - SET_W'(1);
          end
        end
        ST_LOCKED: begin
          if (meas_valid && exit_c) begin
            win_n = '0;
            if (changed_c) begin
              lna_n     = adj_lna_c;
              vga_n     = adj_vga_c;
              upd_n     = 1'b1;
              state_n   = ST_SETTLE;
              set_cnt_n = SET_LOAD;
            end else begin
              state_n = ST_TRACK;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lna_q     <= LNA_MAX_V;
      vga_q     <= '1;
      set_cnt_q <= '0;
      win_q     <= '0;
      gain_upd  <= 1'b0;
      settling  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_n;
      lna_q     <= lna_n;
      vga_q     <= vga_n;
      set_cnt_q <= set_cnt_n;
      win_q     <= win_n;
      gain_upd  <= upd_n;
      settling  <= (state_n == ST_SETTLE);
      locked    <= (state_n == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_agc_ctrl_param.sv
// Directed bench for agc_ctrl_param at default parameters; observed word is
// {gain_out, gain_upd, settling, locked}.
module tb_agc_ctrl_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       manual = 1'b0;
  logic [6:0] man_gain_in = '0;
  logic       meas_valid = 1'b0;
  logic [7:0] rssi_in = '0;
  logic [7:0] pwr_in = '0;
  logic [6:0] gain_out;
  logic       gain_upd, settling, locked;
  logic [9:0] obs;

  int n_vec = 0;
  int n_err = 0;

  assign obs = {gain_out, gain_upd, settling, locked};

  always #5 clk = ~clk;

  agc_ctrl_param dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .manual      (manual),
    .man_gain_in (man_gain_in),
    .meas_valid  (meas_valid),
    .rssi_in     (rssi_in),
    .pwr_in      (pwr_in),
    .gain_out    (gain_out),
    .gain_upd    (gain_upd),
    .settling    (settling),
    .locked      (locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic meas(input logic [7:0] r, input logic [7:0] p);
    meas_valid = 1'b1;
    rssi_in    = r;
    pwr_in     = p;
    tick();
    meas_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] exp_v;
    reset = 1'b1;
    tick();
    tick();
    exp_v = {7'h7F, 3'b000};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset: got %h exp %h", obs, exp_v); end
    reset = 1'b0;
    meas(8'd100, 8'd160);
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL disabled_hold: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_track_settle();
    logic [9:0] exp_v;
    en = 1'b1;
    tick();
    meas(8'd100, 8'd160);
    exp_v = {7'h7E, 3'b110};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL first_adjust: got %h exp %h", obs, exp_v); end
    for (int i = 0; i < 4; i++) begin
      meas(8'd100, 8'd160);
      exp_v = (i < 3) ? {7'h7E, 3'b010} : {7'h7E, 3'b000};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL settle_%0d: got %h exp %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_lna_step();
    logic [7:0] r_t [4] = '{8'd200, 8'd200, 8'd200, 8'd50};
    logic [7:0] p_t [4] = '{8'd120, 8'd120, 8'd160, 8'd120};
    logic [6:0] g_t [4] = '{7'h4D, 7'h2D, 7'h2C, 7'h48};
    logic [9:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      meas(r_t[i], p_t[i]);
      exp_v = {g_t[i], 3'b110};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL lna_step_%0d: got %h exp %h", i, obs, exp_v); end
      repeat (4) tick();
      exp_v = {g_t[i], 3'b000};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL lna_settled_%0d: got %h exp %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_lock_hyst();
    logic [9:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      meas(8'd100, 8'd120);
      exp_v = {7'h48, 2'b00, (i == 2)};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL lock_win_%0d: got %h exp %h", i, obs, exp_v); end
    end
    meas(8'd100, 8'd155);
    exp_v = {7'h48, 3'b001};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lock_hold_155: got %h exp %h", obs, exp_v); end
    meas(8'd100, 8'd165);
    exp_v = {7'h47, 3'b110};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lock_exit_165: got %h exp %h", obs, exp_v); end
    repeat (4) tick();
    exp_v = {7'h47, 3'b000};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lock_exit_settled: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_saturation();
    logic [9:0] exp_v;
    manual      = 1'b1;
    man_gain_in = 7'h5F;
    tick();
    exp_v = {7'h5F, 3'b100};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL man_load_hi: got %h exp %h", obs, exp_v); end
    tick();
    exp_v = {7'h5F, 3'b000};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL man_same_no_upd: got %h exp %h", obs, exp_v); end
    manual = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      meas(8'd100, 8'd50);
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL sat_hi_%0d: got %h exp %h", i, obs, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      meas(8'd100, 8'd120);
      exp_v = {7'h5F, 2'b00, (i == 2)};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL sat_lock_%0d: got %h exp %h", i, obs, exp_v); end
    end
    meas(8'd100, 8'd85);
    exp_v = {7'h5F, 3'b001};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL hyst_hold_85: got %h exp %h", obs, exp_v); end
    meas(8'd100, 8'd70);
    exp_v = {7'h5F, 3'b000};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL railed_unlock: got %h exp %h", obs, exp_v); end
    manual      = 1'b1;
    man_gain_in = 7'h40;
    tick();
    exp_v = {7'h40, 3'b100};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL man_load_lo: got %h exp %h", obs, exp_v); end
    manual = 1'b0;
    tick();
    exp_v = {7'h40, 3'b000};
    for (int i = 0; i < 3; i++) begin
      meas(8'd100, 8'd200);
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL sat_lo_%0d: got %h exp %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_manual_reset();
    logic [9:0] exp_v;
    manual      = 1'b1;
    man_gain_in = 7'h25;
    tick();
    exp_v = {7'h25, 3'b100};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL man_25: got %h exp %h", obs, exp_v); end
    manual = 1'b0;
    tick();
    meas(8'd100, 8'd160);
    exp_v = {7'h24, 3'b110};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL man_then_track: got %h exp %h", obs, exp_v); end
    tick();
    reset = 1'b1;
    tick();
    exp_v = {7'h7F, 3'b000};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_mid_settle: got %h exp %h", obs, exp_v); end
    reset = 1'b0;
    meas(8'd100, 8'd160);
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL idle_ignores_meas: got %h exp %h", obs, exp_v); end
    meas(8'd100, 8'd160);
    exp_v = {7'h7E, 3'b110};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL track_after_reset: got %h exp %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_track_settle();
    test_lna_step();
    test_lock_hyst();
    test_saturation();
    test_manual_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
